// File: rtl/test_run_scheduler_if.sv
// Handshake bundle between the JTAG command source, the test engine and the
// register file write port. The scheduler sits on the slave side.
interface test_run_scheduler_if;
  logic        cmd_valid;
  logic [3:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        test_start;
  logic [3:0]  test_id;
  logic        test_done;
  logic [31:0] test_result;
  logic        reg_we;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;

  modport master (
    output cmd_valid, cmd_opcode, cmd_data,
    input  test_start, test_id,
    output test_done, test_result,
    input  reg_we, reg_addr, reg_wdata
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_data,
    output test_start, test_id,
    input  test_done, test_result,
    output reg_we, reg_addr, reg_wdata
  );
endinterface

// File: rtl/test_run_scheduler.sv
// Arbitrates JTAG and button run requests into a one-deep slot, sequences the
// test engine with timeout, and shares the register file write port.
module test_run_scheduler #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int TIMEOUT_CYCLES  = 4000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sw_n,
  test_run_scheduler_if.slave  bus,
  output logic [3:0]           sel_test,
  output logic [3:0]           run_count,
  output logic [1:0]           state_code,
  output logic                 err_timeout
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LOAD  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] OP_SETREG   = 4'h3;
  localparam logic [3:0] OP_RUNTEST  = 4'h4;
  localparam logic [3:0] OP_WRITEREG = 4'h7;
  localparam logic [3:0] OP_SELTEST  = 4'hE;
  localparam logic [2:0] WB_ADDR     = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_RUNNING   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               sw_s1_q, sw_s2_q, sw_s3_q;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [2:0]         reg_ptr_q, reg_ptr_d;
  logic [3:0]         sel_test_q, sel_test_d;
  logic               pend_valid_q, pend_valid_d;
  logic [3:0]         pend_id_q, pend_id_d;
  logic [3:0]         test_id_q, test_id_d;
  logic               test_start_q, test_start_d;
  logic [3:0]         run_count_q, run_count_d;
  logic               err_q, err_d;
  logic               wbuf_valid_q, wbuf_valid_d;
  logic [2:0]         wbuf_addr_q, wbuf_addr_d;
  logic [31:0]        wbuf_data_q, wbuf_data_d;
  logic               reg_we_q, reg_we_d;
  logic [2:0]         reg_addr_q, reg_addr_d;
  logic [31:0]        reg_wdata_q, reg_wdata_d;

  logic               cmd_setreg, cmd_runtest, cmd_writereg, cmd_seltest;
  logic               press;
  logic               wb_go;
  logic [31:0]        capt;

  always_comb begin
    cmd_setreg   = bus.cmd_valid && (bus.cmd_opcode == OP_SETREG);
    cmd_runtest  = bus.cmd_valid && (bus.cmd_opcode == OP_RUNTEST);
    cmd_writereg = bus.cmd_valid && (bus.cmd_opcode == OP_WRITEREG);
    cmd_seltest  = bus.cmd_valid && (bus.cmd_opcode == OP_SELTEST);
    // Falling edge of the synchronised button, only while debounce is idle.
    press        = sw_s3_q && !sw_s2_q && (db_cnt_q == '0);

    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    reg_ptr_d    = reg_ptr_q;
    sel_test_d   = sel_test_q;
    pend_valid_d = pend_valid_q;
    pend_id_d    = pend_id_q;
    test_id_d    = test_id_q;
    test_start_d = 1'b0;
    run_count_d  = run_count_q;
    err_d        = err_q;
    wbuf_valid_d = wbuf_valid_q;
    wbuf_addr_d  = wbuf_addr_q;
    wbuf_data_d  = wbuf_data_q;
    reg_we_d     = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    wb_go        = 1'b0;
    capt         = 32'h0;

    if (press) begin
      db_cnt_d = DB_LOAD;
    end else if (db_cnt_q != '0) begin
      db_cnt_d = db_cnt_q - DB_W'(1);
    end

    if (cmd_setreg) begin
      reg_ptr_d = bus.cmd_data[2:0];
    end
    if (cmd_seltest || cmd_runtest) begin
      sel_test_d = bus.cmd_data[3:0];
    end

    case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          state_d      = S_LAUNCH;
          test_id_d    = pend_id_q;
          pend_valid_d = 1'b0;
          test_start_d = 1'b1;
          run_count_d  = run_count_q + 4'd1;
        end
      end
      S_LAUNCH: begin
        state_d   = S_RUNNING;
        tmo_cnt_d = '0;
      end
      S_RUNNING: begin
        // A completion arriving on the timeout cycle takes precedence.
        if (bus.test_done) begin
          state_d = S_WRITEBACK;
          wb_go   = 1'b1;
          capt    = bus.test_result;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = S_WRITEBACK;
          wb_go   = 1'b1;
          err_d   = 1'b1;
          capt    = {28'hDEAD000, test_id_q};
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_WRITEBACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // New requests land after the slot is consumed, so a same-cycle launch
    // and request leave the new request pending.
    if (cmd_runtest) begin
      pend_valid_d = 1'b1;
      pend_id_d    = bus.cmd_data[3:0];
    end else if (press) begin
      pend_valid_d = 1'b1;
      pend_id_d    = sel_test_q;
    end

    if (wb_go) begin
      reg_we_d    = 1'b1;
      reg_addr_d  = WB_ADDR;
      reg_wdata_d = capt;
      if (cmd_writereg) begin
        wbuf_valid_d = 1'b1;
        wbuf_addr_d  = reg_ptr_q;
        wbuf_data_d  = bus.cmd_data;
      end
    end else if (wbuf_valid_q) begin
      reg_we_d     = 1'b1;
      reg_addr_d   = wbuf_addr_q;
      reg_wdata_d  = wbuf_data_q;
      wbuf_valid_d = cmd_writereg;
      if (cmd_writereg) begin
        wbuf_addr_d = reg_ptr_q;
        wbuf_data_d = bus.cmd_data;
      end
    end else if (cmd_writereg) begin
      reg_we_d    = 1'b1;
      reg_addr_d  = reg_ptr_q;
      reg_wdata_d = bus.cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sw_s1_q      <= 1'b1;
      sw_s2_q      <= 1'b1;
      sw_s3_q      <= 1'b1;
      db_cnt_q     <= '0;
      tmo_cnt_q    <= '0;
      reg_ptr_q    <= '0;
      sel_test_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_id_q    <= '0;
      test_id_q    <= '0;
      test_start_q <= 1'b0;
      run_count_q  <= '0;
      err_q        <= 1'b0;
      wbuf_valid_q <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_data_q  <= '0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      sw_s1_q      <= sw_n;
      sw_s2_q      <= sw_s1_q;
      sw_s3_q      <= sw_s2_q;
      db_cnt_q     <= db_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      reg_ptr_q    <= reg_ptr_d;
      sel_test_q   <= sel_test_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
      test_id_q    <= test_id_d;
      test_start_q <= test_start_d;
      run_count_q  <= run_count_d;
      err_q        <= err_d;
      wbuf_valid_q <= wbuf_valid_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_data_q  <= wbuf_data_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
    end
  end

  assign bus.test_start = test_start_q;
  assign bus.test_id    = test_id_q;
  assign bus.reg_we     = reg_we_q;
  assign bus.reg_addr   = reg_addr_q;
  assign bus.reg_wdata  = reg_wdata_q;
  assign sel_test       = sel_test_q;
  assign run_count      = run_count_q;
  assign state_code     = state_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_test_run_scheduler.sv
// Directed bench for test_run_scheduler with shortened debounce/timeout.
module tb_test_run_scheduler;
  localparam int DEB = 40;
  localparam int TMO = 30;

  logic clk;
  logic reset;
  logic sw_n;
  logic [3:0] sel_test;
  logic [3:0] run_count;
  logic [1:0] state_code;
  logic err_timeout;

  int total;
  int bad;
  int cyc;
  int starts;
  logic [3:0] sid;

  test_run_scheduler_if bus();

  test_run_scheduler #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_n       (sw_n),
    .bus        (bus),
    .sel_test   (sel_test),
    .run_count  (run_count),
    .state_code (state_code),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [31:0] d);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_data   = d;
    tick();
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = 4'h0;
    bus.cmd_data   = 32'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    sw_n  = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_opcode  = 4'h0;
    bus.cmd_data    = 32'h0;
    bus.test_done   = 1'b0;
    bus.test_result = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_start", 32'(bus.test_start), 32'h0);
    chk("rst_id", 32'(bus.test_id), 32'h0);
    chk("rst_we", 32'(bus.reg_we), 32'h0);
    chk("rst_wdata", bus.reg_wdata, 32'h0);
    chk("rst_state", 32'(state_code), 32'h0);
    chk("rst_runcnt", 32'(run_count), 32'h0);
    chk("rst_err", 32'(err_timeout), 32'h0);

    // Basic run of test 5
    send_cmd(4'h4, 32'h5);
    chk("rt5_pend_state", 32'(state_code), 32'h0);
    tick();
    chk("rt5_start", 32'(bus.test_start), 32'h1);
    chk("rt5_id", 32'(bus.test_id), 32'h5);
    chk("rt5_state_launch", 32'(state_code), 32'h1);
    chk("rt5_runcnt", 32'(run_count), 32'h1);
    chk("rt5_sel", 32'(sel_test), 32'h5);
    tick();
    chk("rt5_state_run", 32'(state_code), 32'h2);
    chk("rt5_start_low", 32'(bus.test_start), 32'h0);
    tick();
    tick();
    bus.test_done   = 1'b1;
    bus.test_result = 32'h12345678;
    tick();
    bus.test_done   = 1'b0;
    chk("rt5_we", 32'(bus.reg_we), 32'h1);
    chk("rt5_addr", 32'(bus.reg_addr), 32'h4);
    chk("rt5_wdata", bus.reg_wdata, 32'h12345678);
    chk("rt5_state_wb", 32'(state_code), 32'h3);
    tick();
    chk("rt5_we_low", 32'(bus.reg_we), 32'h0);
    chk("rt5_idle", 32'(state_code), 32'h0);

    // Requests during a run: last one wins, then it times out
    send_cmd(4'h4, 32'h1);
    tick();
    tick();
    send_cmd(4'h4, 32'h3);
    tick();
    send_cmd(4'h4, 32'h9);
    tick();
    bus.test_done   = 1'b1;
    bus.test_result = 32'hA1;
    tick();
    bus.test_done   = 1'b0;
    chk("rep_wb_data", bus.reg_wdata, 32'hA1);
    chk("rep_err_before", 32'(err_timeout), 32'h0);
    tick();
    chk("rep_idle", 32'(state_code), 32'h0);
    tick();
    chk("rep_start", 32'(bus.test_start), 32'h1);
    chk("rep_id", 32'(bus.test_id), 32'h9);
    chk("rep_runcnt", 32'(run_count), 32'h3);
    cyc = 0;
    while (!bus.reg_we && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("tmo_we_seen", 32'(bus.reg_we), 32'h1);
    chk("tmo_latency", 32'(cyc), 32'd31);
    chk("tmo_addr", 32'(bus.reg_addr), 32'h4);
    chk("tmo_wdata", bus.reg_wdata, 32'hDEAD0009);
    chk("tmo_err", 32'(err_timeout), 32'h1);
    tick();
    tick();
    tick();
    chk("rep_no_relaunch_state", 32'(state_code), 32'h0);
    chk("rep_no_relaunch_cnt", 32'(run_count), 32'h3);

    // WRITEREG paths
    send_cmd(4'h3, 32'h2);
    tick();
    send_cmd(4'h7, 32'h11223344);
    chk("wr_we", 32'(bus.reg_we), 32'h1);
    chk("wr_addr", 32'(bus.reg_addr), 32'h2);
    chk("wr_data", bus.reg_wdata, 32'h11223344);
    tick();
    chk("wr_we_low", 32'(bus.reg_we), 32'h0);
    send_cmd(4'h4, 32'h6);
    tick();
    chk("rt6_start", 32'(bus.test_start), 32'h1);
    chk("rt6_runcnt", 32'(run_count), 32'h4);
    tick();
    tick();
    bus.test_done   = 1'b1;
    bus.test_result = 32'hCAFEF00D;
    bus.cmd_valid   = 1'b1;
    bus.cmd_opcode  = 4'h7;
    bus.cmd_data    = 32'h0BADBEEF;
    tick();
    bus.test_done   = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_opcode  = 4'h0;
    bus.cmd_data    = 32'h0;
    chk("coll_wb_we", 32'(bus.reg_we), 32'h1);
    chk("coll_wb_addr", 32'(bus.reg_addr), 32'h4);
    chk("coll_wb_data", bus.reg_wdata, 32'hCAFEF00D);
    tick();
    chk("coll_jtag_we", 32'(bus.reg_we), 32'h1);
    chk("coll_jtag_addr", 32'(bus.reg_addr), 32'h2);
    chk("coll_jtag_data", bus.reg_wdata, 32'h0BADBEEF);
    tick();
    chk("coll_we_low", 32'(bus.reg_we), 32'h0);
    chk("err_sticky", 32'(err_timeout), 32'h1);

    // Button with bounce
    send_cmd(4'hE, 32'h7);
    tick();
    chk("btn_sel", 32'(sel_test), 32'h7);
    starts = 0;
    sid = 4'h0;
    for (int i = 0; i < 12; i++) begin
      sw_n = (i < 6) ? ((i % 2) == 1) : 1'b0;
      tick();
      if (bus.test_start) begin
        starts++;
        sid = bus.test_id;
      end
    end
    chk("btn_one_launch", 32'(starts), 32'd1);
    chk("btn_id", 32'(sid), 32'h7);
    chk("btn_runcnt", 32'(run_count), 32'h5);
    bus.test_done   = 1'b1;
    bus.test_result = 32'h0;
    sw_n = 1'b1;
    tick();
    bus.test_done = 1'b0;
    tick();
    starts = 0;
    sw_n = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 3) sw_n = 1'b1;
      tick();
      if (bus.test_start) starts++;
    end
    chk("btn_debounced", 32'(starts), 32'd0);
    chk("btn_debounced_state", 32'(state_code), 32'h0);
    sw_n = 1'b0;
    cyc = 0;
    while (!bus.test_start && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("btn2_start", 32'(bus.test_start), 32'h1);
    chk("btn2_latency", 32'(cyc), 32'd4);
    chk("btn2_id", 32'(bus.test_id), 32'h7);
    chk("btn2_runcnt", 32'(run_count), 32'h6);
    tick();
    bus.test_done = 1'b1;
    tick();
    bus.test_done = 1'b0;
    sw_n = 1'b1;
    tick();
    tick();

    // Reset while running
    send_cmd(4'h4, 32'hA);
    tick();
    tick();
    tick();
    chk("mid_running", 32'(state_code), 32'h2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.test_done   = 1'b1;
    bus.test_result = 32'h55;
    tick();
    bus.test_done   = 1'b0;
    chk("mr_we", 32'(bus.reg_we), 32'h0);
    chk("mr_state", 32'(state_code), 32'h0);
    chk("mr_runcnt", 32'(run_count), 32'h0);
    chk("mr_err", 32'(err_timeout), 32'h0);
    chk("mr_id", 32'(bus.test_id), 32'h0);
    chk("mr_sel", 32'(sel_test), 32'h0);
    chk("mr_wdata", bus.reg_wdata, 32'h0);
    tick();
    chk("mr_we_later", 32'(bus.reg_we), 32'h0);
    send_cmd(4'h4, 32'h2);
    tick();
    chk("post_start", 32'(bus.test_start), 32'h1);
    chk("post_id", 32'(bus.test_id), 32'h2);
    chk("post_runcnt", 32'(run_count), 32'h1);
    tick();
    bus.test_done   = 1'b1;
    bus.test_result = 32'h77;
    tick();
    bus.test_done   = 1'b0;
    chk("post_we", 32'(bus.reg_we), 32'h1);
    chk("post_wdata", bus.reg_wdata, 32'h77);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
